// File: rtl/truth_table_checker.sv
// truth_table_checker: exhaustive sweep of a small combinational circuit.
// Drives every input pattern in ascending order, samples the circuit output
// once per pattern, and compares the captured truth table against a latched
// expected table (pass/fail, mismatch count, lowest failing pattern).
module truth_table_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   truth_table,
  output logic [N_IN:0]          mismatch_count,
  output logic [N_IN-1:0]        first_fail,
  output logic                   first_fail_valid
);

  localparam int                NP       = 1 << N_IN;
  localparam logic [N_IN-1:0]   IDX_LAST = '1;
  localparam logic [N_IN-1:0]   IDX_ONE  = N_IN'(1);
  localparam logic [N_IN:0]     CNT_ONE  = (N_IN+1)'(1);
  localparam logic [3:0]        SETTLE_L = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [NP-1:0]     exp_q, exp_d;
  logic [NP-1:0]     tt_q, tt_d;
  logic [N_IN:0]     mc_q, mc_d;
  logic [N_IN-1:0]   ff_q, ff_d;
  logic              ffv_q, ffv_d;
  logic              pass_q, pass_d;
  logic              miss;

  // State and result registers, cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      mc_q    <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      mc_q    <= mc_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state: start a sweep from IDLE/DONE, hold each pattern SETTLE+1 cycles,
  // sample and compare on the cycle the settle counter reaches zero.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    mc_d    = mc_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;
    miss    = dut_out ^ exp_q[idx_q];
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = APPLY;
          exp_d   = expected;
          tt_d    = '0;
          mc_d    = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = SETTLE_L;
        end
      end
      APPLY: begin
        if (cnt_q == '0) begin
          tt_d[idx_q] = dut_out;
          if (miss) begin
            mc_d = mc_q + CNT_ONE;
            if (!ffv_q) begin
              ff_d  = idx_q;
              ffv_d = 1'b1;
            end
          end
          if (idx_q == IDX_LAST) begin
            // pass must include the final sample, which is not yet in mc_q
            state_d = DONE;
            pass_d  = (mc_q == '0) && !miss;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_ONE;
            cnt_d = SETTLE_L;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The index register is zero outside APPLY, so it drives dut_in directly.
  assign dut_in           = idx_q;
  assign busy             = (state_q == APPLY);
  assign done             = (state_q == DONE);
  assign pass             = pass_q;
  assign truth_table      = tt_q;
  assign mismatch_count   = mc_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: SETTLE=1 and SETTLE=0 instances, each
// driving a modelled combinational circuit, checked against a truth-table model.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  // instance A: N_IN=4, SETTLE=1
  logic        start_a = 1'b0;
  logic [15:0] exp_a = '0;
  logic [3:0]  din_a;
  logic        dout_a;
  logic        busy_a, done_a, pass_a, ffv_a;
  logic [15:0] tt_a;
  logic [4:0]  mc_a;
  logic [3:0]  ff_a;
  int          mode_a = 0;
  logic [15:0] tab_a = '0;

  // instance B: N_IN=4, SETTLE=0
  logic        start_b = 1'b0;
  logic [15:0] exp_b = '0;
  logic [3:0]  din_b;
  logic        dout_b;
  logic        busy_b, done_b, pass_b, ffv_b;
  logic [15:0] tt_b;
  logic [4:0]  mc_b;
  logic [3:0]  ff_b;
  int          mode_b = 0;
  logic [15:0] tab_b = '0;

  truth_table_checker #(.N_IN(4), .SETTLE(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .expected(exp_a),
    .dut_in(din_a), .dut_out(dout_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .truth_table(tt_a), .mismatch_count(mc_a),
    .first_fail(ff_a), .first_fail_valid(ffv_a)
  );

  truth_table_checker #(.N_IN(4), .SETTLE(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .expected(exp_b),
    .dut_in(din_b), .dut_out(dout_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .truth_table(tt_b), .mismatch_count(mc_b),
    .first_fail(ff_b), .first_fail_valid(ffv_b)
  );

  // circuit under check: 0 = 4-input AND, 1 = 4-input XOR, else lookup table
  function automatic logic circ(input int mode, input logic [15:0] tab, input logic [3:0] x);
    case (mode)
      0:       return &x;
      1:       return ^x;
      default: return tab[x];
    endcase
  endfunction

  always_comb dout_a = circ(mode_a, tab_a, din_a);
  always_comb dout_b = circ(mode_b, tab_b, din_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // reference results for a full sweep
  task automatic model(input int mode, input logic [15:0] tab, input logic [15:0] expv,
                       output logic [15:0] mtt, output int mc, output int ff, output bit ffv);
    mc = 0; ff = 0; ffv = 0;
    for (int p = 0; p < 16; p++) begin
      mtt[p] = circ(mode, tab, 4'(p));
      if (mtt[p] != expv[p]) begin
        mc++;
        if (!ffv) begin ff = p; ffv = 1; end
      end
    end
  endtask

  task automatic sweep_a(input string tag, input int mode, input logic [15:0] tab,
                         input logic [15:0] expv, input int restart_at, input bit flip_exp);
    logic [15:0] mtt; int mc, ff; bit ffv; int cyc, bad;
    model(mode, tab, expv, mtt, mc, ff, ffv);
    @(negedge clk);
    mode_a = mode; tab_a = tab; exp_a = expv; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check({tag, "_busy_at_start"}, busy_a, 1);
    check({tag, "_done_at_start"}, done_a, 0);
    cyc = 0; bad = 0;
    if (din_a !== 4'd0) bad++;
    while (done_a !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      start_a = (cyc == restart_at);
      if (flip_exp && cyc == 3) exp_a = ~expv;
      if (done_a !== 1'b1 && din_a !== 4'(cyc / 2)) bad++;
    end
    start_a = 1'b0;
    check({tag, "_latency"}, cyc, 32);
    check({tag, "_dut_in_steps"}, bad, 0);
    check({tag, "_dut_in_done"}, din_a, 0);
    check({tag, "_busy_done"}, busy_a, 0);
    check({tag, "_tt"}, tt_a, mtt);
    check({tag, "_mc"}, mc_a, mc);
    check({tag, "_ff"}, ff_a, ff);
    check({tag, "_ffv"}, ffv_a, ffv);
    check({tag, "_pass"}, pass_a, (mc == 0));
    @(posedge clk); #1;
    check({tag, "_held"}, {done_a, tt_a}, {1'b1, mtt});
  endtask

  task automatic sweep_b(input string tag, input int mode, input logic [15:0] tab,
                         input logic [15:0] expv);
    logic [15:0] mtt; int mc, ff; bit ffv; int cyc, bad;
    model(mode, tab, expv, mtt, mc, ff, ffv);
    @(negedge clk);
    mode_b = mode; tab_b = tab; exp_b = expv; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check({tag, "_busy_at_start"}, busy_b, 1);
    cyc = 0; bad = 0;
    while (done_b !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done_b !== 1'b1 && din_b !== 4'(cyc)) bad++;
    end
    check({tag, "_latency"}, cyc, 16);
    check({tag, "_dut_in_steps"}, bad, 0);
    check({tag, "_tt"}, tt_b, mtt);
    check({tag, "_mc"}, mc_b, mc);
    check({tag, "_ff"}, {ffv_b, ff_b}, {ffv, 4'(ff)});
    check({tag, "_pass"}, pass_b, (mc == 0));
  endtask

  initial begin
    logic [15:0] t, m;
    #12;
    check("reset_a", {busy_a, done_a, pass_a, din_a, tt_a, mc_a, ff_a, ffv_a}, '0);
    check("reset_b", {busy_b, done_b, pass_b, din_b, tt_b, mc_b, ff_b, ffv_b}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_a", {busy_a, done_a}, 0);

    sweep_a("and_ok", 0, '0, 16'h8000, -1, 0);
    sweep_a("and_bad", 0, '0, 16'h8001, -1, 0);
    sweep_a("xor_inv", 1, '0, 16'h9669, -1, 0);
    sweep_a("restart_ign", 1, '0, 16'h6996, 5, 1);
    sweep_a("and_redo", 0, '0, 16'h8000, -1, 0);

    // reset in the middle of an XOR sweep
    @(negedge clk);
    mode_a = 1; exp_a = 16'h6996; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_outs", {busy_a, done_a, din_a, tt_a, mc_a, ffv_a}, '0);
    @(negedge clk);
    rst = 1'b0;
    sweep_a("after_rst", 1, '0, 16'h6996, -1, 0);

    for (int k = 0; k < 3; k++) begin
      t = 16'($urandom);
      m = 16'($urandom & $urandom & $urandom);
      sweep_a($sformatf("rand%0d", k), 2, t, t ^ m, -1, 0);
    end

    sweep_b("b_and_ok", 0, '0, 16'h8000);
    t = 16'($urandom);
    sweep_b("b_rand", 2, t, t ^ 16'($urandom & $urandom));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
Self-contained sequential checker for small combinational circuits with N_IN inputs and one output. On start it sweeps all 2^N_IN input patterns in ascending order and samples the circuit output once per pattern. It assembles the captured truth table and compares it bit-by-bit against an expected table, then reports pass/fail, the mismatch count and the lowest failing pattern. It is the hardware response side of the exhaustive-stimulus flow, so circuit checks run in synthesised logic without a simulator $monitor.

Parameters:
N_IN, 4, number of circuit inputs; the sweep covers 2^N_IN patterns (legal 1..8).
SETTLE, 1, extra cycles each pattern is held before sampling (legal 0..15).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-high reset.
start  input  1  one-cycle request to begin a sweep.
expected  input  2^N_IN  expected output; bit i corresponds to input pattern i.
dut_in  output  N_IN  pattern driven to the circuit under check.
dut_out  input  1  circuit output; assumed settled within SETTLE+1 cycles.
busy  output  1  high while a sweep is in progress.
done  output  1  high in the DONE state; results are valid.
pass  output  1  valid when done=1; 1 means zero mismatches.
truth_table  output  2^N_IN  captured outputs; bit i is the sample for pattern i.
mismatch_count  output  N_IN+1  number of differing bits, range 0..2^N_IN.
first_fail  output  N_IN  lowest pattern index that mismatched.
first_fail_valid  output  1  1 if any mismatch occurred.

Behaviour:
- Reset (async, immediate, also mid-sweep): state=IDLE, dut_in=0, busy=0, done=0, pass=0, truth_table=0, mismatch_count=0, first_fail=0, first_fail_valid=0, internal index and settle counter=0.
- States: IDLE, APPLY, DONE.
- IDLE, start=1 at edge E0:
  - latch expected into an internal register; later changes to the expected input are ignored until the next start.
  - clear truth_table, mismatch_count, first_fail and first_fail_valid.
  - index=0, dut_in=0, settle counter=SETTLE, busy=1. Go to APPLY.
- APPLY: dut_in=index throughout.
  - Each pattern is held for exactly SETTLE+1 cycles.
  - On an edge where the settle counter is 0:
    - truth_table[index] <= dut_out.
    - If dut_out != latched expected[index]: mismatch_count increments; if first_fail_valid=0, then first_fail <= index and first_fail_valid <= 1.
    - If index = 2^N_IN-1: go to DONE; busy=0, done=1, dut_in=0, and pass = (no mismatches, including this last sample).
    - Otherwise index increments, dut_in follows, and the settle counter reloads to SETTLE.
  - Otherwise the settle counter decrements.
- Timing:
  - Pattern i is sampled at edge E0 + (i+1)(SETTLE+1).
  - done rises at edge E0 + 2^N_IN*(SETTLE+1). For N_IN=4, SETTLE=1 that is 32 cycles.
- DONE:
  - Results and done are held indefinitely; dut_in=0.
  - start=1 begins a new sweep exactly as from IDLE, and done drops at that edge.
- start while busy=1 is ignored and has no effect on index, results or timing.
- The index register is N_IN+1 bits wide, or terminal detection is on 2^N_IN-1, so no wrap-around aliasing occurs. mismatch_count reaches 2^N_IN without overflow.
- Outputs are registered; no combinational path from dut_out to any output.

Test Plan:
- N_IN=4, SETTLE=1, circuit = 4-input AND, expected=16'h8000, start pulse -> dut_in steps 0..15 every 2 cycles; done=1 exactly 32 cycles after start; truth_table=16'h8000, pass=1, mismatch_count=0, first_fail_valid=0.
- Same circuit, expected=16'h8001 -> pass=0, mismatch_count=1, first_fail=0, first_fail_valid=1, truth_table=16'h8000.
- Circuit = 4-input XOR, expected=16'h9669 (the inverse of 16'h6996) -> truth_table=16'h6996, mismatch_count=16 (5'b10000), first_fail=0, pass=0.
- Assert start again at cycle 5 of a sweep -> ignored; done still at cycle 32 with unchanged results. Then start from DONE with a correct expected -> done drops next edge; fresh results, pass=1.
- Assert rst at cycle 10 of a sweep -> same cycle: busy=0, dut_in=0, truth_table=0, done=0. A subsequent start completes normally.
- SETTLE=0, AND circuit, expected=16'h8000 -> new pattern every cycle; done 16 cycles after start; pass=1.
